cnu_min_10_sched: RTL and testbench

Round-robin scheduler that time-shares one `base_cnu_min_10` min-finder among `REQ_NUM` check-node requesters in the layered decoder. It registers the granted requester's ten variable-to-check messages and runs them through the min-finder. It then returns min, second min and both indices, tagged with the requester ID, over a valid/ready result port with full back-pressure.

---
 rtl/cnu_min_10_sched.sv | 200 ++++++++++++++++++++
 tb/tb_cnu_min_10_sched.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnu_min_10_sched.sv
// cnu_min_10_sched: round-robin scheduler sharing one 10-input min-finder
// among REQ_NUM check-node requesters in the layered decoder.
//
// Ports:
//   sys_clk, rst (async, active-high), flush (sync clear)
//   req_valid/req_ready : per-requester handshake, req_ready is one-hot
//   req_msg             : requester r, message k at
//                         [(r*CN_DEGREE+k)*QUAN_SIZE +: QUAN_SIZE]
//   res_valid/res_ready : result handshake with full back-pressure
//   res_id, res_m1, res_m2, res_min_1_index, res_min_2_index : result
//
// Optional feature macro: CNU_SCHED_STALL_CNT_EN
//   adds output stall_cnt[15:0], a saturating count of cycles with
//   res_valid & !res_ready, cleared by rst and flush.

module cnu_min_10_sched #(
    parameter int CN_DEGREE          = 10,
    parameter int QUAN_SIZE          = 3,
    parameter int REQ_NUM            = 4,
    parameter int MIN_INDEX_BITWIDTH = $clog2(CN_DEGREE),
    parameter int REQ_ID_BITWIDTH    = $clog2(REQ_NUM)
) (
    input  logic                                   sys_clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [REQ_NUM-1:0]                     req_valid,
    input  logic [REQ_NUM*CN_DEGREE*QUAN_SIZE-1:0] req_msg,
    output logic [REQ_NUM-1:0]                     req_ready,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [REQ_ID_BITWIDTH-1:0]             res_id,
    output logic [QUAN_SIZE-1:0]                   res_m1,
    output logic [QUAN_SIZE-1:0]                   res_m2,
    output logic [MIN_INDEX_BITWIDTH-1:0]          res_min_1_index,
    output logic [MIN_INDEX_BITWIDTH-1:0]          res_min_2_index
`ifdef CNU_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]                            stall_cnt
`endif
);

    localparam int MSG_W = CN_DEGREE * QUAN_SIZE;
    localparam logic [REQ_ID_BITWIDTH-1:0] PTR_INIT =
        REQ_ID_BITWIDTH'(REQ_NUM - 1);

    // Arbiter pointer: last granted requester
    logic [REQ_ID_BITWIDTH-1:0]    r_ptr;

    // Stage 1: granted messages and requester tag
    logic                          r_s1_valid;
    logic [MSG_W-1:0]              r_s1_msg;
    logic [REQ_ID_BITWIDTH-1:0]    r_s1_id;

    // Stage 2: result registers
    logic                          r_res_valid;
    logic [REQ_ID_BITWIDTH-1:0]    r_res_id;
    logic [QUAN_SIZE-1:0]          r_res_m1;
    logic [QUAN_SIZE-1:0]          r_res_m2;
    logic [MIN_INDEX_BITWIDTH-1:0] r_res_i1;
    logic [MIN_INDEX_BITWIDTH-1:0] r_res_i2;

    logic                          w_found;
    logic [REQ_ID_BITWIDTH-1:0]    w_win_id;
    int                            w_idx;
    logic                          w_s2_load;
    logic                          w_s1_load_ok;
    logic                          w_grant_en;
    logic                          w_hs;

    logic [QUAN_SIZE-1:0]          w_msg;
    logic [QUAN_SIZE-1:0]          w_m1;
    logic [QUAN_SIZE-1:0]          w_m2;
    logic [MIN_INDEX_BITWIDTH-1:0] w_i1;
    logic [MIN_INDEX_BITWIDTH-1:0] w_i2;

    // Round-robin search starting one past the last winner, with wrap
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_idx    = 0;
        for (int off = 1; off <= REQ_NUM; off++) begin
            w_idx = (int'(r_ptr) + off) % REQ_NUM;
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = REQ_ID_BITWIDTH'(w_idx);
            end
        end
    end

    assign w_s2_load    = r_s1_valid & (~r_res_valid | res_ready);
    assign w_s1_load_ok = ~r_s1_valid | w_s2_load;

    // Grant only when S1 can take data; flush and reset suppress it
    assign w_grant_en = w_s1_load_ok & w_found & ~flush & ~rst;
    assign req_ready  = w_grant_en ? (REQ_NUM'(1) << w_win_id) : '0;
    assign w_hs       = w_grant_en;

    // Min-finder: strict-less scan, so ties keep the lower index
    always_comb begin
        w_msg = '0;
        w_m1  = r_s1_msg[0 +: QUAN_SIZE];
        w_i1  = '0;
        w_m2  = r_s1_msg[QUAN_SIZE +: QUAN_SIZE];
        w_i2  = MIN_INDEX_BITWIDTH'(1);
        if (w_m2 < w_m1) begin
            w_m1 = r_s1_msg[QUAN_SIZE +: QUAN_SIZE];
            w_i1 = MIN_INDEX_BITWIDTH'(1);
            w_m2 = r_s1_msg[0 +: QUAN_SIZE];
            w_i2 = '0;
        end
        for (int k = 2; k < CN_DEGREE; k++) begin
            w_msg = r_s1_msg[k*QUAN_SIZE +: QUAN_SIZE];
            if (w_msg < w_m1) begin
                w_m2 = w_m1;
                w_i2 = w_i1;
                w_m1 = w_msg;
                w_i1 = MIN_INDEX_BITWIDTH'(k);
            end else if (w_msg < w_m2) begin
                w_m2 = w_msg;
                w_i2 = MIN_INDEX_BITWIDTH'(k);
            end
        end
    end

    // Stage 1 and arbiter pointer
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= PTR_INIT;
            r_s1_valid <= 1'b0;
            r_s1_msg   <= '0;
            r_s1_id    <= '0;
        end else if (flush) begin
            r_ptr      <= PTR_INIT;
            r_s1_valid <= 1'b0;
            r_s1_msg   <= '0;
            r_s1_id    <= '0;
        end else begin
            if (w_s1_load_ok) begin
                r_s1_valid <= w_hs;
            end
            if (w_hs) begin
                r_ptr    <= w_win_id;
                r_s1_id  <= w_win_id;
                r_s1_msg <= req_msg[int'(w_win_id)*MSG_W +: MSG_W];
            end
        end
    end

    // Stage 2: holds while the consumer stalls
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_m1    <= '0;
            r_res_m2    <= '0;
            r_res_i1    <= '0;
            r_res_i2    <= '0;
        end else if (flush) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_m1    <= '0;
            r_res_m2    <= '0;
            r_res_i1    <= '0;
            r_res_i2    <= '0;
        end else if (~r_res_valid | res_ready) begin
            r_res_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res_id <= r_s1_id;
                r_res_m1 <= w_m1;
                r_res_m2 <= w_m2;
                r_res_i1 <= w_i1;
                r_res_i2 <= w_i2;
            end
        end
    end

    assign res_valid       = r_res_valid;
    assign res_id          = r_res_id;
    assign res_m1          = r_res_m1;
    assign res_m2          = r_res_m2;
    assign res_min_1_index = r_res_i1;
    assign res_min_2_index = r_res_i2;

`ifdef CNU_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt <= '0;
        end else if (r_res_valid & ~res_ready & (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cnu_min_10_sched.sv
// Testbench for cnu_min_10_sched: directed scenarios plus a randomized
// run checked against a sort-based min model and a result scoreboard.

module tb_cnu_min_10_sched;

    localparam int CN = 10;
    localparam int Q  = 3;
    localparam int RN = 4;
    localparam int IW = 4;
    localparam int RW = 2;

    logic                 sys_clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [RN-1:0]        req_valid;
    logic [RN*CN*Q-1:0]   req_msg;
    logic [RN-1:0]        req_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [RW-1:0]        res_id;
    logic [Q-1:0]         res_m1;
    logic [Q-1:0]         res_m2;
    logic [IW-1:0]        res_min_1_index;
    logic [IW-1:0]        res_min_2_index;
`ifdef CNU_SCHED_STALL_CNT_EN
    logic [15:0]          stall_cnt;
`endif

    cnu_min_10_sched dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .flush           (flush),
        .req_valid       (req_valid),
        .req_msg         (req_msg),
        .req_ready       (req_ready),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_id          (res_id),
        .res_m1          (res_m1),
        .res_m2          (res_m2),
        .res_min_1_index (res_min_1_index),
        .res_min_2_index (res_min_2_index)
`ifdef CNU_SCHED_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int id;
        int m1;
        int i1;
        int m2;
        int i2;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    int msgs [RN][CN];

    // Reference: smallest and next-smallest (value, index) keys
    function automatic exp_t ref_res(input int r);
        exp_t e;
        int best;
        int second;
        int key;
        best = 1 << 20;
        for (int k = 0; k < CN; k++) begin
            key = msgs[r][k] * 16 + k;
            if (key < best) best = key;
        end
        second = 1 << 20;
        for (int k = 0; k < CN; k++) begin
            key = msgs[r][k] * 16 + k;
            if (key != best && key < second) second = key;
        end
        e.id = r;
        e.m1 = best / 16;
        e.i1 = best % 16;
        e.m2 = second / 16;
        e.i2 = second % 16;
        return e;
    endfunction

    function automatic int rr_pick(input logic [RN-1:0] v, input int p);
        for (int off = 1; off <= RN; off++) begin
            if (v[(p + off) % RN]) return (p + off) % RN;
        end
        return -1;
    endfunction

    task automatic drive_msgs();
        for (int r = 0; r < RN; r++)
            for (int k = 0; k < CN; k++)
                req_msg[(r*CN+k)*Q +: Q] = Q'(msgs[r][k]);
    endtask

    task automatic rand_msgs();
        for (int r = 0; r < RN; r++)
            for (int k = 0; k < CN; k++)
                msgs[r][k] = $urandom_range(0, 7);
        drive_msgs();
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        req_valid = 4'hF;
        res_ready = 1'b1;
        rand_msgs();
        #3;
        tick();
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        n_tests++;
        if ({res_valid, res_id, res_m1, res_m2, res_min_1_index, res_min_2_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_res got v=%b id=%0d m1=%0d m2=%0d exp all 0",
                     res_valid, res_id, res_m1, res_m2);
        end
`ifdef CNU_SCHED_STALL_CNT_EN
        n_tests++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall got=%0d exp=0", stall_cnt);
        end
`endif
        req_valid = 4'h0;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int v [CN];
        v = '{5, 3, 7, 1, 6, 4, 2, 7, 5, 6};
        tick();
        for (int k = 0; k < CN; k++) msgs[2][k] = v[k];
        drive_msgs();
        req_valid = 4'b0100;
        res_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant got=%b exp=0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        n_tests++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early got=%b exp=0", res_valid);
        end
        tick();
        n_tests++;
        if ({res_valid, res_id, res_m1, res_min_1_index, res_m2, res_min_2_index} !==
            {1'b1, 2'd2, 3'd1, 4'd3, 3'd2, 4'd6}) begin
            n_fail++;
            $display("FAIL single_res got v=%b id=%0d m1=%0d i1=%0d m2=%0d i2=%0d exp 1 2 1 3 2 6",
                     res_valid, res_id, res_m1, res_min_1_index, res_m2, res_min_2_index);
        end
        tick();
        n_tests++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_index_range();
        tick();
        for (int k = 0; k < CN; k++) msgs[1][k] = 7;
        msgs[1][9] = 0;
        msgs[1][8] = 1;
        drive_msgs();
        req_valid = 4'b0010;
        res_ready = 1'b1;
        tick();
        req_valid = 4'b0000;
        tick();
        n_tests++;
        if ({res_valid, res_id, res_m1, res_min_1_index, res_m2, res_min_2_index} !==
            {1'b1, 2'd1, 3'd0, 4'd9, 3'd1, 4'd8}) begin
            n_fail++;
            $display("FAIL index_res got v=%b id=%0d m1=%0d i1=%0d m2=%0d i2=%0d exp 1 1 0 9 1 8",
                     res_valid, res_id, res_m1, res_min_1_index, res_m2, res_min_2_index);
        end
        tick();
    endtask

    task automatic test_fairness();
        exp_t ex [8];
        exp_t e;
        do_flush();
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) begin
                e = ex[i-2];
                n_tests++;
                if ({res_valid, res_id, res_m1, res_min_1_index, res_m2, res_min_2_index} !==
                    {1'b1, RW'(e.id), Q'(e.m1), IW'(e.i1), Q'(e.m2), IW'(e.i2)}) begin
                    n_fail++;
                    $display("FAIL fair_res%0d got v=%b id=%0d m1=%0d i1=%0d exp id=%0d m1=%0d i1=%0d",
                             i, res_valid, res_id, res_m1, res_min_1_index, e.id, e.m1, e.i1);
                end
            end
            rand_msgs();
            req_valid = (i < 6) ? 4'hF : 4'h0;
            #1;
            if (i < 6) begin
                n_tests++;
                if (req_ready !== (4'b0001 << (i % RN))) begin
                    n_fail++;
                    $display("FAIL fair_grant%0d got=%b exp=%b",
                             i, req_ready, 4'b0001 << (i % RN));
                end
                ex[i] = ref_res(i % RN);
            end
            tick();
        end
        n_tests++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fair_end got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_back_pressure();
        exp_t e0;
        exp_t e1;
        do_flush();
        res_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c >= 2) begin
                n_tests++;
                if ({res_valid, res_id, res_m1, res_min_1_index, res_m2, res_min_2_index} !==
                    {1'b1, RW'(e0.id), Q'(e0.m1), IW'(e0.i1), Q'(e0.m2), IW'(e0.i2)}) begin
                    n_fail++;
                    $display("FAIL bp_hold%0d got v=%b id=%0d m1=%0d exp id=%0d m1=%0d",
                             c, res_valid, res_id, res_m1, e0.id, e0.m1);
                end
            end
            rand_msgs();
            req_valid = 4'hF;
            #1;
            n_tests++;
            if (req_ready !== ((c < 2) ? (4'b0001 << c) : 4'b0000)) begin
                n_fail++;
                $display("FAIL bp_grant%0d got=%b", c, req_ready);
            end
            if (c == 0) e0 = ref_res(0);
            if (c == 1) e1 = ref_res(1);
            tick();
        end
`ifdef CNU_SCHED_STALL_CNT_EN
        n_tests++;
        if (stall_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt);
        end
`endif
        n_tests++;
        if ({res_valid, res_id, res_m1, res_min_1_index, res_m2, res_min_2_index} !==
            {1'b1, RW'(e0.id), Q'(e0.m1), IW'(e0.i1), Q'(e0.m2), IW'(e0.i2)}) begin
            n_fail++;
            $display("FAIL bp_drain0 got v=%b id=%0d exp id=%0d", res_valid, res_id, e0.id);
        end
        req_valid = 4'h0;
        res_ready = 1'b1;
        tick();
        n_tests++;
        if ({res_valid, res_id, res_m1, res_min_1_index, res_m2, res_min_2_index} !==
            {1'b1, RW'(e1.id), Q'(e1.m1), IW'(e1.i1), Q'(e1.m2), IW'(e1.i2)}) begin
            n_fail++;
            $display("FAIL bp_drain1 got v=%b id=%0d exp id=%0d", res_valid, res_id, e1.id);
        end
        tick();
        n_tests++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_flush();
        do_flush();
        res_ready = 1'b1;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        res_ready = 1'b0;
        req_valid = 4'hF;
        flush = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_ready got=%b exp=0000", req_ready);
        end
        tick();
        flush = 1'b0;
        n_tests++;
        if ({res_valid, res_id, res_m1, res_m2, res_min_1_index, res_min_2_index} !== '0) begin
            n_fail++;
            $display("FAIL flush_res got v=%b id=%0d m1=%0d exp all 0", res_valid, res_id, res_m1);
        end
        res_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL flush_ptr got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = 4'h0;
        tick();
        n_tests++;
        if ({res_valid, res_id} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL flush_next got v=%b id=%0d exp v=1 id=0", res_valid, res_id);
        end
        tick();
    endtask

    task automatic test_async_reset();
        res_ready = 1'b1;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({res_valid, res_id, res_m1, res_m2, res_min_1_index, res_min_2_index} !== '0 ||
            req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid got v=%b id=%0d rdy=%b exp all 0", res_valid, res_id, req_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_ptr got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = 4'h0;
        tick();
        n_tests++;
        if ({res_valid, res_id} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL rst_next got v=%b id=%0d exp v=1 id=0", res_valid, res_id);
        end
        tick();
    endtask

    task automatic test_sparse();
        logic [RN-1:0] vs [7];
        logic [RN-1:0] gs [7];
        vs = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b1010};
        gs = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
        do_flush();
        res_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 2 || c == 5) begin
                n_tests++;
                if ({res_valid, res_id} !== {1'b1, (c == 2) ? 2'd3 : 2'd0}) begin
                    n_fail++;
                    $display("FAIL sparse_res%0d got v=%b id=%0d", c, res_valid, res_id);
                end
            end
            req_valid = vs[c];
            #1;
            n_tests++;
            if (req_ready !== gs[c]) begin
                n_fail++;
                $display("FAIL sparse_grant%0d got=%b exp=%b", c, req_ready, gs[c]);
            end
            tick();
        end
        req_valid = 4'h0;
        tick();
        tick();
    endtask

    task automatic test_random();
        exp_t sb [$];
        exp_t e;
        int   m_ptr;
        bit   m_s1;
        bit   m_s2;
        bit   consume;
        bit   s2ld;
        bit   canld;
        int   g;
        logic [RN-1:0] expg;
        do_flush();
        m_ptr = RN - 1;
        m_s1 = 0;
        m_s2 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_tests++;
            if (res_valid !== m_s2) begin
                n_fail++;
                $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, res_valid, m_s2);
            end
            if (m_s2 && sb.size() > 0) begin
                e = sb[0];
                n_tests++;
                if ({res_id, res_m1, res_min_1_index, res_m2, res_min_2_index} !==
                    {RW'(e.id), Q'(e.m1), IW'(e.i1), Q'(e.m2), IW'(e.i2)}) begin
                    n_fail++;
                    $display("FAIL rand_res cyc=%0d got id=%0d m1=%0d i1=%0d m2=%0d i2=%0d exp %0d %0d %0d %0d %0d",
                             cyc, res_id, res_m1, res_min_1_index, res_m2, res_min_2_index,
                             e.id, e.m1, e.i1, e.m2, e.i2);
                end
            end
            req_valid = RN'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            rand_msgs();
            #1;
            consume = m_s2 && res_ready;
            s2ld    = m_s1 && (!m_s2 || res_ready);
            canld   = !m_s1 || s2ld;
            g       = canld ? rr_pick(req_valid, m_ptr) : -1;
            expg    = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            n_tests++;
            if (req_ready !== expg) begin
                n_fail++;
                $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_ready, expg);
            end
            if (consume) void'(sb.pop_front());
            if (g >= 0) begin
                sb.push_back(ref_res(g));
                m_ptr = g;
            end
            if (s2ld) m_s2 = 1;
            else if (consume) m_s2 = 0;
            if (canld) m_s1 = (g >= 0);
            tick();
        end
        req_valid = 4'h0;
        res_ready = 1'b1;
        tick();
        tick();
        tick();
        n_tests++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain got=%b exp=0", res_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_index_range();
        test_fairness();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_sparse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
